// File: rtl/bcd_to_binary.sv
// Three-digit BCD to binary converter using reverse double-dabble.
// One bit of binary result is produced per SHIFT cycle; result and flags are registered at FINISH.
module bcd_to_binary #(
    parameter int BCD_DIGITS = 3,
    parameter int NUM_BITS   = 32,
    parameter int ITER       = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [3:0]          hundreds,
    input  logic [3:0]          tens,
    input  logic [3:0]          units,
    output logic [NUM_BITS-1:0] binary_out,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam int WORK_W = 4 * BCD_DIGITS + ITER;
    localparam int CNT_W  = $clog2(ITER + 1);
    localparam logic [CNT_W-1:0] ITER_CNT = CNT_W'(ITER);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t            state, state_next;
    logic [WORK_W-1:0] work, work_next, work_step;
    logic [CNT_W-1:0]  count, count_next;
    logic              err_flag, err_flag_next;
    logic              digits_bad;

    assign digits_bad = (hundreds > 4'd9) || (tens > 4'd9) || (units > 4'd9);
    assign busy       = (state != IDLE);

    // One reverse double-dabble step: shift right, then correct every BCD field that reached 8 or more.
    always_comb begin
        work_step = work >> 1;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (work_step[ITER + 4*d +: 4] >= 4'd8) begin
                work_step[ITER + 4*d +: 4] = work_step[ITER + 4*d +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        state_next    = state;
        work_next     = work;
        count_next    = count;
        err_flag_next = err_flag;
        case (state)
            IDLE: begin
                if (start) begin
                    if (digits_bad) begin
                        err_flag_next = 1'b1;
                        work_next     = '0;
                        count_next    = '0;
                        state_next    = FINISH;
                    end else begin
                        err_flag_next = 1'b0;
                        work_next     = {hundreds, tens, units, {ITER{1'b0}}};
                        count_next    = ITER_CNT;
                        state_next    = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_next  = work_step;
                count_next = count - CNT_W'(1);
                if (count_next == '0) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are captured on the edge that leaves FINISH and then held until the next conversion ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            work       <= '0;
            count      <= '0;
            err_flag   <= 1'b0;
            binary_out <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state    <= state_next;
            work     <= work_next;
            count    <= count_next;
            err_flag <= err_flag_next;
            done     <= (state == FINISH);
            if (state == FINISH) begin
                binary_out <= err_flag ? '0 : {{(NUM_BITS-ITER){1'b0}}, work[ITER-1:0]};
                error      <= err_flag;
            end
        end
    end

endmodule
